mem_sequencer: RTL
==================

// Module: mem_sequencer
// PURPOSE
//  CPU-side initiator for the single-port block-RAM memory. Accepts fetch and
//  load/store requests from the core, arbitrates them, and generates the
//  d_read/i_read -> d_push/i_push read sequence and the d_write strobe.
//  Drives d_bus for writes and captures d_bus on reads. Never drives d_bus
//  while the memory may be pushing.
// PARAMETERS
//  MEM_WORDS   256  words implemented; addr >= MEM_WORDS is out of range
//  FETCH_PRIO  0    0: data wins simultaneous requests; 1: fetch wins
// PORTS
//  clk         in   1   system clock, all state on posedge
//  rst         in   1   asynchronous, active-high reset
//  fetch_req   in   1   instruction fetch request (level, held until ack)
//  fetch_addr  in   16  fetch word address
//  fetch_ack   out  1   one-cycle pulse: instr valid this cycle
//  instr       out  16  fetched word, held until next fetch completes
//  data_req    in   1   load/store request (level, held until ack)
//  data_we     in   1   1 = store, 0 = load
//  data_addr   in   16  load/store word address
//  data_wdata  in   16  store data
//  data_ack    out  1   one-cycle pulse: load data valid / store done
//  data_rdata  out  16  loaded word, held until next load completes
//  addr_err    out  1   one-cycle pulse with ack: address out of range
//  busy        out  1   1 in any state except IDLE
//  d_read      out  1   memory data-side read strobe
//  d_write     out  1   memory write strobe
//  d_push      out  1   memory: drive latched data-side word onto d_bus
//  i_read      out  1   memory instruction-side read strobe
//  i_push      out  1   memory: drive latched instr word onto d_bus
//  d_addr      out  16  data-side address
//  i_addr      out  16  instruction-side address
//  d_bus       inout 16 shared bus; driven only in WR, else 16'bz
// BEHAVIOUR
//  - States: IDLE, RD_ADDR, RD_PUSH, WR, ACK. Strobes are a Moore decode of
//    the state register plus an op-type flag; no glitches.
//  - IDLE: sample requests at posedge. Both high -> FETCH_PRIO decides.
//    On accept, latch addr/we/wdata/type. Operands may change after accept.
//  - In range: load/fetch -> RD_ADDR; store -> WR. Out of range -> ACK
//    directly with addr_err=1, no memory strobe, rdata/instr <= 16'h0000.
//  - RD_ADDR (1 cycle): d_read (load) or i_read (fetch) = 1, address valid.
//  - RD_PUSH (1 cycle): d_push or i_push = 1; capture d_bus into data_rdata
//    or instr at the posedge ending this cycle.
//  - WR (1 cycle): d_write=1, d_addr valid, d_bus = latched wdata.
//  - ACK (1 cycle): matching ack=1, then IDLE. A req still high in IDLE is a
//    new request.
//  - Latency from accepting edge to ack: load/fetch 3 cycles, store 2,
//    out-of-range 1. Max one access in flight; no queueing.
//  - Exactly one of d_read/i_read/d_write/d_push/i_push high at a time.
//    d_bus is never driven in IDLE, RD_ADDR, RD_PUSH or ACK.
//  - Unused address output holds its last value. Both are 16'h0000 after
//    reset.
//  - Reset (any time, incl. mid-op): state=IDLE, all strobes/acks/addr_err/
//    busy=0, d_bus=z immediately; instr, data_rdata, d_addr, i_addr = 0.
//    The in-flight op is dropped with no ack.
// TESTING
//  1 Preload mem[16]=16'hB000. Fetch addr 16 -> i_read 1 cyc, i_push 1 cyc,
//    fetch_ack 3 cyc after accept, instr=16'hB000.
//  2 Store 16'h1234 to 16'h0040, then load 16'h0040 -> d_write 1 cyc with
//    bus=1234; load returns data_rdata=16'h1234 with data_ack.
//  3 fetch_req and data_req rise together, FETCH_PRIO=0 -> data serviced
//    first; fetch accepted in the IDLE after data_ack; both acked.
//  4 Load from 16'h0100 (MEM_WORDS=256) -> no strobes, data_ack+addr_err
//    one cycle after accept, data_rdata=0.
//  5 Assert rst during RD_PUSH -> strobes drop and d_bus=z without a clock,
//    no ack; first post-reset fetch completes normally.
//  6 Bus-contention monitor across random req mix: never (d_bus driven &&
//    (d_push||i_push)); never >1 strobe high.

Source files
------------

// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - CPU-side request/response bundle for mem_sequencer
interface mem_sequencer_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] instr;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic        data_ack;
  logic [15:0] data_rdata;
  logic        addr_err;
  logic        busy;

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
    input  fetch_ack, instr, data_ack, data_rdata, addr_err, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
    output fetch_ack, instr, data_ack, data_rdata, addr_err, busy
  );
endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - fetch/load/store sequencer for a single-port block RAM
module mem_sequencer #(
  parameter int MEM_WORDS  = 256,
  parameter bit FETCH_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  mem_sequencer_if.slave  cpu,
  output logic            d_read,
  output logic            d_write,
  output logic            d_push,
  output logic            i_read,
  output logic            i_push,
  output logic [15:0]     d_addr,
  output logic [15:0]     i_addr,
  inout  wire  [15:0]     d_bus
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_PUSH, WR, ACK} state_t;

  localparam logic [31:0] LIMIT = MEM_WORDS;

  state_t      state;
  logic        op_fetch;
  logic        op_err;
  logic [15:0] wdata_q;

  logic take_fetch;
  logic take_data;
  logic fetch_ok;
  logic data_ok;

  assign take_fetch = cpu.fetch_req && (!cpu.data_req || FETCH_PRIO);
  assign take_data  = cpu.data_req && !take_fetch;
  assign fetch_ok   = {16'd0, cpu.fetch_addr} < LIMIT;
  assign data_ok    = {16'd0, cpu.data_addr} < LIMIT;

  // Strobes decode straight from state flops so they cannot glitch.
  assign d_read  = (state == RD_ADDR) && !op_fetch;
  assign i_read  = (state == RD_ADDR) &&  op_fetch;
  assign d_push  = (state == RD_PUSH) && !op_fetch;
  assign i_push  = (state == RD_PUSH) &&  op_fetch;
  assign d_write = (state == WR);
  assign d_bus   = (state == WR) ? wdata_q : 16'bz;

  assign cpu.fetch_ack = (state == ACK) &&  op_fetch;
  assign cpu.data_ack  = (state == ACK) && !op_fetch;
  assign cpu.addr_err  = (state == ACK) &&  op_err;
  assign cpu.busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_fetch       <= 1'b0;
      op_err         <= 1'b0;
      wdata_q        <= 16'h0000;
      d_addr         <= 16'h0000;
      i_addr         <= 16'h0000;
      cpu.instr      <= 16'h0000;
      cpu.data_rdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (take_fetch) begin
            op_fetch <= 1'b1;
            op_err   <= !fetch_ok;
            i_addr   <= cpu.fetch_addr;
            if (fetch_ok) begin
              state <= RD_ADDR;
            end else begin
              cpu.instr <= 16'h0000;
              state     <= ACK;
            end
          end else if (take_data) begin
            op_fetch <= 1'b0;
            op_err   <= !data_ok;
            d_addr   <= cpu.data_addr;
            wdata_q  <= cpu.data_wdata;
            if (!data_ok) begin
              // A rejected store leaves the last loaded word untouched.
              if (!cpu.data_we) cpu.data_rdata <= 16'h0000;
              state <= ACK;
            end else begin
              state <= cpu.data_we ? WR : RD_ADDR;
            end
          end
        end
        RD_ADDR: state <= RD_PUSH;
        RD_PUSH: begin
          if (op_fetch) cpu.instr      <= d_bus;
          else          cpu.data_rdata <= d_bus;
          state <= ACK;
        end
        WR:      state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
